// File: rtl/memory_hs.sv
// memory_hs: single-port data memory with req/ready handshake, registered read port,
// power-up/on-demand clear sweep and address range checking. Optional MEMORY_HS_PARITY_EN.
module memory_hs #(
   parameter int unsigned     BITS     = 16,
   parameter int unsigned     MEMADDRS = 256,
   parameter int unsigned     AW       = 8,
   parameter logic [BITS-1:0] INIT_VAL = '0
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_clear,
   input  logic            i_req,
   input  logic            i_rw,
   input  logic [AW-1:0]   i_addr,
   input  logic [BITS-1:0] i_data,
   output logic            o_ready,
   output logic            o_rvalid,
   output logic [BITS-1:0] o_data,
   output logic            o_err,
`ifdef MEMORY_HS_PARITY_EN
   output logic            o_perr,
`endif
   output logic            o_init_done
);

   if (MEMADDRS < 1 || (64'(1) << AW) < 64'(MEMADDRS)) begin : g_bad_cfg
      $error("memory_hs: MEMADDRS must lie in 1..2**AW");
   end

   localparam int unsigned IW       = (MEMADDRS > 1) ? $clog2(MEMADDRS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(MEMADDRS - 1);
`ifdef MEMORY_HS_PARITY_EN
   localparam int unsigned WW = BITS + 1;
`else
   localparam int unsigned WW = BITS;
`endif

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_IDLE  = 1'b1;

   logic [WW-1:0] mem [0:MEMADDRS-1];
   logic [0:0]    state;
   logic [IW-1:0] cnt;
   logic          in_range;
   logic          accept;
   logic          rd_acc;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;
   logic [WW-1:0] wr_word;
   logic [WW-1:0] rd_word;

   function automatic logic [WW-1:0] encode(input logic [BITS-1:0] d);
`ifdef MEMORY_HS_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   // A full-depth array has no out-of-range addresses, so skip the compare entirely.
   if (64'(MEMADDRS) == (64'(1) << AW)) begin : g_full
      assign in_range = 1'b1;
   end else begin : g_part
      assign in_range = (i_addr <= AW'(MEMADDRS - 1));
   end

   assign o_ready = (state == ST_IDLE) && !i_clear;
   assign accept  = o_ready && i_req;
   assign rd_acc  = accept && !i_rw;
   assign rd_idx  = i_addr[IW-1:0];
   assign rd_word = mem[rd_idx];

   // Sweep and request writes are mutually exclusive by state, so one write port suffices.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = cnt;
      wr_word = encode(INIT_VAL);
      if (state == ST_CLEAR) begin
         wr_en = !i_clear;
      end else if (accept && i_rw && in_range) begin
         wr_en   = 1'b1;
         wr_idx  = rd_idx;
         wr_word = encode(i_data);
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_word;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_CLEAR;
         cnt         <= '0;
         o_init_done <= 1'b0;
         o_rvalid    <= 1'b0;
         o_data      <= '0;
         o_err       <= 1'b0;
`ifdef MEMORY_HS_PARITY_EN
         o_perr      <= 1'b0;
`endif
      end else begin
         o_rvalid <= rd_acc;
         o_err    <= accept && !in_range;
`ifdef MEMORY_HS_PARITY_EN
         o_perr   <= rd_acc && in_range && (^rd_word);
`endif
         if (rd_acc) begin
            o_data <= in_range ? rd_word[BITS-1:0] : '0;
         end
         case (state)
            ST_CLEAR: begin
               if (i_clear) begin
                  cnt <= '0;
               end else if (cnt == LAST_IDX) begin
                  state       <= ST_IDLE;
                  o_init_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if (i_clear) begin
                  state       <= ST_CLEAR;
                  cnt         <= '0;
                  o_init_done <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_hs.sv
// Testbench for memory_hs: a full-depth and a partial-depth instance share stimulus and are
// checked against array reference models.
`timescale 1ns/1ps
module tb_memory_hs;
   localparam int unsigned BITS  = 16;
   localparam int unsigned AW    = 8;
   localparam int unsigned N_BIG = 256;
   localparam int unsigned N_SML = 200;
   localparam logic [BITS-1:0] INIT = 16'hA5C3;

   logic            i_clk   = 1'b0;
   logic            i_rst_n = 1'b1;
   logic            i_clear = 1'b0;
   logic            i_req   = 1'b0;
   logic            i_rw    = 1'b0;
   logic [AW-1:0]   i_addr  = '0;
   logic [BITS-1:0] i_data  = '0;

   logic            b_ready, b_rvalid, b_err, b_init_done;
   logic [BITS-1:0] b_data;
   logic            s_ready, s_rvalid, s_err, s_init_done;
   logic [BITS-1:0] s_data;
`ifdef MEMORY_HS_PARITY_EN
   logic            b_perr, s_perr;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   logic [BITS-1:0] ref_big [N_BIG];
   logic [BITS-1:0] ref_sml [N_SML];

   memory_hs #(.BITS(BITS), .MEMADDRS(N_BIG), .AW(AW), .INIT_VAL(INIT)) dut_big (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_req(i_req), .i_rw(i_rw),
      .i_addr(i_addr), .i_data(i_data), .o_ready(b_ready), .o_rvalid(b_rvalid),
      .o_data(b_data), .o_err(b_err),
`ifdef MEMORY_HS_PARITY_EN
      .o_perr(b_perr),
`endif
      .o_init_done(b_init_done));

   memory_hs #(.BITS(BITS), .MEMADDRS(N_SML), .AW(AW), .INIT_VAL(INIT)) dut_sml (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_req(i_req), .i_rw(i_rw),
      .i_addr(i_addr), .i_data(i_data), .o_ready(s_ready), .o_rvalid(s_rvalid),
      .o_data(s_data), .o_err(s_err),
`ifdef MEMORY_HS_PARITY_EN
      .o_perr(s_perr),
`endif
      .o_init_done(s_init_done));

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded, got timeout exp completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic reset_models();
      for (int i = 0; i < int'(N_BIG); i++) ref_big[i] = INIT;
      for (int i = 0; i < int'(N_SML); i++) ref_sml[i] = INIT;
   endtask

   // Edges until each instance reports ready; -1 if it never does within the budget.
   task automatic wait_init(output int nb, output int ns);
      nb = -1;
      ns = -1;
      for (int c = 1; c <= 400; c++) begin
         tick();
         if (ns < 0 && s_ready === 1'b1) ns = c;
         if (nb < 0 && b_ready === 1'b1) begin
            nb = c;
            break;
         end
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [BITS-1:0] d);
      i_req = 1'b1; i_rw = 1'b1; i_addr = a; i_data = d;
      ref_big[a] = d;
      if (int'(a) < int'(N_SML)) ref_sml[a] = d;
      tick();
      i_req = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      i_req = 1'b1; i_rw = 1'b0; i_addr = a;
      tick();
      i_req = 1'b0;
   endtask

   task automatic test_reset();
      int nb, ns;
      #2 i_rst_n = 1'b0;
      #1;
      n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b exp 0", b_ready); end
      n_cmp++; if (b_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b exp 0", b_rvalid); end
      n_cmp++; if (b_data !== 16'h0) begin n_bad++; $display("FAIL rst_data: got %h exp 0000", b_data); end
      n_cmp++; if (b_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b exp 0", b_err); end
      n_cmp++; if (b_init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init_done: got %b exp 0", b_init_done); end
      tick();
      i_rst_n = 1'b1;
      wait_init(nb, ns);
      reset_models();
      n_cmp++; if (nb != 256) begin n_bad++; $display("FAIL rst_sweep_big: got %0d exp 256", nb); end
      n_cmp++; if (ns != 200) begin n_bad++; $display("FAIL rst_sweep_sml: got %0d exp 200", ns); end
      n_cmp++; if (b_init_done !== 1'b1) begin n_bad++; $display("FAIL rst_init_done_set: got %b exp 1", b_init_done); end
      rd(8'h00);
      n_cmp++; if (b_rvalid !== 1'b1 || b_data !== INIT) begin n_bad++; $display("FAIL rst_rd00: got rv=%b %h exp rv=1 %h", b_rvalid, b_data, INIT); end
      rd(8'hFF);
      n_cmp++; if (b_rvalid !== 1'b1 || b_data !== INIT) begin n_bad++; $display("FAIL rst_rdFF: got rv=%b %h exp rv=1 %h", b_rvalid, b_data, INIT); end
      n_cmp++; if (s_err !== 1'b1 || s_data !== 16'h0) begin n_bad++; $display("FAIL rst_rdFF_sml: got err=%b %h exp err=1 0000", s_err, s_data); end
   endtask

   task automatic test_write_read();
      wr(8'h05, 16'h1234);
      n_cmp++; if (b_rvalid !== 1'b0 || b_err !== 1'b0) begin n_bad++; $display("FAIL wr_resp: got rv=%b err=%b exp 0 0", b_rvalid, b_err); end
      rd(8'h05);
      n_cmp++; if (b_rvalid !== 1'b1 || b_data !== 16'h1234) begin n_bad++; $display("FAIL raw_rd: got rv=%b %h exp rv=1 1234", b_rvalid, b_data); end
      tick();
      n_cmp++; if (b_rvalid !== 1'b0 || b_data !== 16'h1234) begin n_bad++; $display("FAIL rd_hold: got rv=%b %h exp rv=0 1234", b_rvalid, b_data); end
   endtask

   task automatic test_back_to_back();
      logic [BITS-1:0] exp;
      for (int i = 0; i < 4; i++) wr(AW'(i), BITS'(16'h00A0 + i));
      for (int i = 0; i < 4; i++) begin
         i_req = 1'b1; i_rw = 1'b0; i_addr = AW'(i);
         tick();
         exp = BITS'(16'h00A0 + i);
         n_cmp++; if (b_rvalid !== 1'b1 || b_data !== exp) begin n_bad++; $display("FAIL b2b_rd%0d: got rv=%b %h exp rv=1 %h", i, b_rvalid, b_data, exp); end
      end
      i_req = 1'b0;
      tick();
      n_cmp++; if (b_rvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got rv=%b exp 0", b_rvalid); end
   endtask

   task automatic test_out_of_range();
      wr(8'hC7, 16'h1357);
      n_cmp++; if (s_err !== 1'b0) begin n_bad++; $display("FAIL oor_wrC7_err: got %b exp 0", s_err); end
      wr(8'hC8, 16'hBEEF);
      n_cmp++; if (s_err !== 1'b1 || b_err !== 1'b0) begin n_bad++; $display("FAIL oor_wrC8_err: got sml=%b big=%b exp 1 0", s_err, b_err); end
      tick();
      n_cmp++; if (s_err !== 1'b0) begin n_bad++; $display("FAIL oor_err_pulse: got %b exp 0", s_err); end
      rd(8'hC8);
      n_cmp++; if (s_rvalid !== 1'b1 || s_err !== 1'b1 || s_data !== 16'h0) begin n_bad++; $display("FAIL oor_rdC8: got rv=%b err=%b %h exp 1 1 0000", s_rvalid, s_err, s_data); end
      n_cmp++; if (b_data !== 16'hBEEF) begin n_bad++; $display("FAIL oor_rdC8_big: got %h exp beef", b_data); end
      rd(8'hC7);
      n_cmp++; if (s_rvalid !== 1'b1 || s_err !== 1'b0 || s_data !== 16'h1357) begin n_bad++; $display("FAIL oor_rdC7: got rv=%b err=%b %h exp 1 0 1357", s_rvalid, s_err, s_data); end
   endtask

   task automatic test_random();
      logic req, rw;
      logic [AW-1:0] a;
      logic [BITS-1:0] d;
      logic [BITS-1:0] eb, es;
      logic erv, eserr;
      eb = '0; es = '0;
      for (int k = 0; k < 300; k++) begin
         req = ($urandom_range(0, 3) != 0);
         rw  = 1'($urandom_range(0, 1));
         if (k == 0) begin req = 1'b1; rw = 1'b0; end
         a = AW'($urandom_range(0, 255));
         d = BITS'($urandom);
         i_req = req; i_rw = rw; i_addr = a; i_data = d;
         erv   = req && !rw;
         eserr = req && (int'(a) >= int'(N_SML));
         if (erv) begin
            eb = ref_big[a];
            es = (int'(a) < int'(N_SML)) ? ref_sml[a] : '0;
         end
         if (req && rw) begin
            ref_big[a] = d;
            if (int'(a) < int'(N_SML)) ref_sml[a] = d;
         end
         #1;
         n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_ready: got %b exp 1", k, b_ready); end
         tick();
         n_cmp++; if (b_rvalid !== erv || b_data !== eb || b_err !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_big: got rv=%b %h err=%b exp rv=%b %h err=0", k, b_rvalid, b_data, b_err, erv, eb); end
         n_cmp++; if (s_rvalid !== erv || s_data !== es || s_err !== eserr) begin n_bad++; $display("FAIL rnd%0d_sml: got rv=%b %h err=%b exp rv=%b %h err=%b", k, s_rvalid, s_data, s_err, erv, es, eserr); end
      end
      i_req = 1'b0;
   endtask

   task automatic test_clear_priority();
      int nb, ns;
      wr(8'h10, 16'h5555);
      i_clear = 1'b1; i_req = 1'b1; i_rw = 1'b0; i_addr = 8'h10;
      #1;
      n_cmp++; if (b_ready !== 1'b0 || s_ready !== 1'b0) begin n_bad++; $display("FAIL clr_ready: got %b %b exp 0 0", b_ready, s_ready); end
      tick();
      i_clear = 1'b0; i_req = 1'b0;
      n_cmp++; if (b_init_done !== 1'b0 || b_rvalid !== 1'b0 || s_rvalid !== 1'b0) begin n_bad++; $display("FAIL clr_noaccept: got done=%b rv=%b/%b exp 0 0/0", b_init_done, b_rvalid, s_rvalid); end
      wait_init(nb, ns);
      reset_models();
      n_cmp++; if (nb != 256 || ns != 200) begin n_bad++; $display("FAIL clr_sweep: got %0d/%0d exp 256/200", nb, ns); end
      rd(8'h10);
      n_cmp++; if (b_rvalid !== 1'b1 || b_data !== INIT || s_data !== INIT) begin n_bad++; $display("FAIL clr_rd10: got rv=%b %h/%h exp 1 %h", b_rvalid, b_data, s_data, INIT); end
   endtask

   task automatic test_reset_mid();
      int nb, ns;
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      #2 i_rst_n = 1'b0;
      #1;
      n_cmp++; if (b_ready !== 1'b0 || b_init_done !== 1'b0 || b_data !== 16'h0) begin n_bad++; $display("FAIL midsweep_rst: got rdy=%b done=%b %h exp 0 0 0000", b_ready, b_init_done, b_data); end
      tick();
      i_rst_n = 1'b1;
      wait_init(nb, ns);
      reset_models();
      n_cmp++; if (nb != 256 || ns != 200) begin n_bad++; $display("FAIL midsweep_resweep: got %0d/%0d exp 256/200", nb, ns); end
      wr(8'h33, 16'h4242);
      i_req = 1'b1; i_rw = 1'b0; i_addr = 8'h33;
      tick();
      n_cmp++; if (b_rvalid !== 1'b1 || b_data !== 16'h4242) begin n_bad++; $display("FAIL midrd_pre: got rv=%b %h exp 1 4242", b_rvalid, b_data); end
      #2 i_rst_n = 1'b0;
      #1;
      i_req = 1'b0;
      n_cmp++; if (b_rvalid !== 1'b0 || b_data !== 16'h0 || b_init_done !== 1'b0) begin n_bad++; $display("FAIL midrd_rst: got rv=%b %h done=%b exp 0 0000 0", b_rvalid, b_data, b_init_done); end
      tick();
      i_rst_n = 1'b1;
      wait_init(nb, ns);
      reset_models();
      n_cmp++; if (nb != 256) begin n_bad++; $display("FAIL midrd_resweep: got %0d exp 256", nb); end
      rd(8'h33);
      n_cmp++; if (b_rvalid !== 1'b1 || b_data !== INIT) begin n_bad++; $display("FAIL midrd_after: got rv=%b %h exp 1 %h", b_rvalid, b_data, INIT); end
   endtask

`ifdef MEMORY_HS_PARITY_EN
   task automatic test_parity();
      wr(8'h05, 16'h00F0);
      dut_big.mem[5] = dut_big.mem[5] ^ 17'h00001;
      rd(8'h05);
      n_cmp++; if (b_perr !== 1'b1 || b_rvalid !== 1'b1 || b_data !== 16'h00F1) begin n_bad++; $display("FAIL par_flip: got perr=%b rv=%b %h exp 1 1 00f1", b_perr, b_rvalid, b_data); end
      rd(8'h06);
      n_cmp++; if (b_perr !== 1'b0) begin n_bad++; $display("FAIL par_clean: got %b exp 0", b_perr); end
      rd(8'hC8);
      n_cmp++; if (s_perr !== 1'b0 || s_err !== 1'b1) begin n_bad++; $display("FAIL par_oor: got perr=%b err=%b exp 0 1", s_perr, s_err); end
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_out_of_range();
      test_random();
      test_clear_priority();
      test_reset_mid();
`ifdef MEMORY_HS_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
